// File: rtl/numled_io_regs_pkg.sv
// Shared constants for the NUMLED register front end: bus widths, register
// offsets and CTRL bit positions.
package numled_io_regs_pkg;

    localparam int IO_BUS_WIDTH_DATA    = 32;
    localparam int DEVICE_NUM_NUMLED_EN = 1;

    localparam logic [1:0] NUMLED_ADDR_DATA   = 2'd0;
    localparam logic [1:0] NUMLED_ADDR_CTRL   = 2'd1;
    localparam logic [1:0] NUMLED_ADDR_STATUS = 2'd2;

    localparam int NUMLED_CTRL_EN    = 0;
    localparam int NUMLED_CTRL_BLINK = 1;

endpackage

// File: rtl/numled_clkdiv.sv
// Toggle divider: clk_out flips every DIV clk cycles; rise flags the cycle
// on which clk_out is about to go 0->1.
module numled_clkdiv #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out,
    output logic rise
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          clk_r;
    logic          term_s;

    assign term_s  = (cnt_r == TERM);
    assign clk_out = clk_r;
    assign rise    = term_s & ~clk_r;

    // Divider counter and output toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            clk_r <= 1'b0;
        end else if (term_s) begin
            cnt_r <= {CW{1'b0}};
            clk_r <= ~clk_r;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/numled_io_regs.sv
// CPU-visible register front end for the 8-digit seven-segment display.
// Hardware blinking is built only when NUMLED_BLINK_EN is defined.
module numled_io_regs
    import numled_io_regs_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_SCANS = 250
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         io_we,
    input  logic                         io_re,
    input  logic [1:0]                   io_addr,
    input  logic [3:0]                   io_be,
    input  logic [IO_BUS_WIDTH_DATA-1:0] io_wdata,
    output logic [IO_BUS_WIDTH_DATA-1:0] io_rdata,
    output logic [IO_BUS_WIDTH_DATA-1:0] num_out,
    output logic                         light,
    output logic                         scan_clk
);

    logic [IO_BUS_WIDTH_DATA-1:0] data_r;
    logic [IO_BUS_WIDTH_DATA-1:0] rdata_r;
    logic [IO_BUS_WIDTH_DATA-1:0] rd_mux_s;
    logic [IO_BUS_WIDTH_DATA-1:0] ctrl_rd_s;
    logic                         en_r;
    logic                         phase_s;
    logic                         scan_clk_s;
    logic                         scan_rise_s;
    logic                         we_data_s;
    logic                         we_ctrl_s;

    assign we_data_s = io_we & (io_addr == NUMLED_ADDR_DATA);
    assign we_ctrl_s = io_we & (io_addr == NUMLED_ADDR_CTRL) & io_be[0];

    assign num_out  = data_r;
    assign io_rdata = rdata_r;
    assign scan_clk = scan_clk_s;

    numled_clkdiv #(
        .DIV (SCAN_DIV)
    ) u_scan_div (
        .clk     (clk),
        .rst     (rst),
        .clk_out (scan_clk_s),
        .rise    (scan_rise_s)
    );

    // DATA register with per-byte write enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {IO_BUS_WIDTH_DATA{1'b0}};
        end else if (we_data_s) begin
            for (int i = 0; i < 4; i++) begin
                if (io_be[i]) begin
                    data_r[8*i +: 8] <= io_wdata[8*i +: 8];
                end
            end
        end
    end

    // CTRL.EN bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r <= 1'b0;
        end else if (we_ctrl_s) begin
            en_r <= io_wdata[NUMLED_CTRL_EN];
        end
    end

`ifdef NUMLED_BLINK_EN
    localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_SCANS - 1);

    logic          blink_r;
    logic          phase_r;
    logic [BW-1:0] blink_cnt_r;
    logic          restart_s;

    // Any write that leaves BLINK off, or turns it on, restarts in the lit phase.
    assign restart_s = we_ctrl_s & (~io_wdata[NUMLED_CTRL_BLINK] | ~blink_r);

    // CTRL.BLINK, blink counter and phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_r     <= 1'b0;
            blink_cnt_r <= {BW{1'b0}};
            phase_r     <= 1'b1;
        end else begin
            if (we_ctrl_s) begin
                blink_r <= io_wdata[NUMLED_CTRL_BLINK];
            end
            if (restart_s) begin
                blink_cnt_r <= {BW{1'b0}};
                phase_r     <= 1'b1;
            end else if (blink_r & scan_rise_s) begin
                if (blink_cnt_r == BLINK_TERM) begin
                    blink_cnt_r <= {BW{1'b0}};
                    phase_r     <= ~phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BW'(1);
                end
            end
        end
    end

    assign phase_s   = phase_r;
    assign light     = en_r & (~blink_r | phase_r);
    assign ctrl_rd_s = {{(IO_BUS_WIDTH_DATA-2){1'b0}}, blink_r, en_r};
`else
    logic unused_scan_rise_s;

    assign unused_scan_rise_s = scan_rise_s;
    assign phase_s   = 1'b1;
    assign light     = en_r;
    assign ctrl_rd_s = {{(IO_BUS_WIDTH_DATA-1){1'b0}}, en_r};
`endif

    // Read-data select from pre-write register values.
    always_comb begin
        rd_mux_s = {IO_BUS_WIDTH_DATA{1'b0}};
        case (io_addr)
            NUMLED_ADDR_DATA:   rd_mux_s = data_r;
            NUMLED_ADDR_CTRL:   rd_mux_s = ctrl_rd_s;
            NUMLED_ADDR_STATUS: rd_mux_s = {{(IO_BUS_WIDTH_DATA-2){1'b0}}, scan_clk_s, phase_s};
            default:            rd_mux_s = {IO_BUS_WIDTH_DATA{1'b0}};
        endcase
    end

    // Read data register; holds until the next read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {IO_BUS_WIDTH_DATA{1'b0}};
        end else if (io_re) begin
            rdata_r <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_numled_io_regs.sv
// Directed, scoreboard-based bench for numled_io_regs (SCAN_DIV=4, BLINK_SCANS=3).
module tb_numled_io_regs;
    import numled_io_regs_pkg::*;

    localparam int SD = 4;
    localparam int BS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [1:0]  io_addr = 2'd0;
    logic [3:0]  io_be = 4'd0;
    logic [31:0] io_wdata = 32'd0;
    logic [31:0] io_rdata;
    logic [31:0] num_out;
    logic        light;
    logic        scan_clk;

    int total = 0;
    int bad = 0;
    int edges = 0;
    logic [31:0] sb_q[$];

    numled_io_regs #(
        .SCAN_DIV    (SD),
        .BLINK_SCANS (BS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_we    (io_we),
        .io_re    (io_re),
        .io_addr  (io_addr),
        .io_be    (io_be),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .num_out  (num_out),
        .light    (light),
        .scan_clk (scan_clk)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; drives the scan_clk model.
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic logic scan_exp(input int e);
        return ((e / SD) % 2) != 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        io_we = 1'b1; io_addr = a; io_be = be; io_wdata = d;
        @(negedge clk);
        io_we = 1'b0; io_be = 4'd0;
    endtask

    task automatic do_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        io_re = 1'b1; io_addr = a;
        sb_q.push_back(exp);
        @(negedge clk);
        io_re = 1'b0;
        check(tag, io_rdata, sb_q.pop_front());
    endtask

    task automatic read_status(input string tag, input logic phase);
        @(negedge clk);
        io_re = 1'b1; io_addr = NUMLED_ADDR_STATUS;
        sb_q.push_back({30'd0, scan_exp(edges), phase});
        @(negedge clk);
        io_re = 1'b0;
        check(tag, io_rdata, sb_q.pop_front());
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check({tag, "_num_out"}, num_out, 32'd0);
        check({tag, "_light"}, {31'd0, light}, 32'd0);
        check({tag, "_scan_clk"}, {31'd0, scan_clk}, 32'd0);
        check({tag, "_rdata"}, io_rdata, 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check({tag, "_scan_div"}, {31'd0, scan_clk}, {31'd0, scan_exp(edges)});
        end
    endtask

    initial begin
        logic       phase;
        int         bcnt;
        logic [31:0] hold;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_num_out", num_out, 32'd0);
        check("rst_light", {31'd0, light}, 32'd0);
        check("rst_rdata", io_rdata, 32'd0);
        check("rst_scan_clk", {31'd0, scan_clk}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("scan_div", {31'd0, scan_clk}, {31'd0, scan_exp(edges)});
        end

        // Byte-enable write and read back
        do_write(NUMLED_ADDR_DATA, 4'b0101, 32'h1234_5678);
        check("be_num_out", num_out, 32'h0034_0078);
        do_read("be_rdata", NUMLED_ADDR_DATA, 32'h0034_0078);
        hold = io_rdata;
        repeat (5) @(negedge clk);
        check("rdata_hold", io_rdata, hold);
        do_write(NUMLED_ADDR_DATA, 4'b1000, 32'hAB00_0000);
        check("be_hi_num_out", num_out, 32'hAB34_0078);

        // Enable
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h1);
        check("en_light_on", {31'd0, light}, 32'd1);
        do_read("ctrl_en_rd", NUMLED_ADDR_CTRL, 32'h1);
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h0);
        check("en_light_off", {31'd0, light}, 32'd0);
        do_write(NUMLED_ADDR_CTRL, 4'b0010, 32'h1);
        check("ctrl_be0_off", {31'd0, light}, 32'd0);

        // STATUS at two different scan phases
        read_status("status_a", 1'b1);
        repeat (3) @(negedge clk);
        read_status("status_b", 1'b1);

`ifdef NUMLED_BLINK_EN
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h3);
        do_read("ctrl_blink_rd", NUMLED_ADDR_CTRL, 32'h3);
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h1);
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h3);
        check("blink_start", {31'd0, light}, 32'd1);
        phase = 1'b1;
        bcnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (edges % (2 * SD) == SD) begin
                bcnt++;
                if (bcnt == BS) begin
                    bcnt = 0;
                    phase = ~phase;
                end
            end
            check("blink_light", {31'd0, light}, {31'd0, phase});
        end
        for (int k = 0; k < 60 && phase; k++) begin
            @(negedge clk);
            if (edges % (2 * SD) == SD) begin
                bcnt++;
                if (bcnt == BS) begin
                    bcnt = 0;
                    phase = ~phase;
                end
            end
            check("blink_wait", {31'd0, light}, {31'd0, phase});
        end
        if (phase) begin
            total++;
            bad++;
            $error("FAIL blink_off_timeout observed=%0d expected=%0d", phase, 0);
        end
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h1);
        check("blink_clear_light", {31'd0, light}, 32'd1);
        read_status("status_after_clear", 1'b1);
`else
        do_write(NUMLED_ADDR_CTRL, 4'b0001, 32'h3);
        check("noblink_light", {31'd0, light}, 32'd1);
        do_read("noblink_ctrl_rd", NUMLED_ADDR_CTRL, 32'h1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("noblink_steady", {31'd0, light}, 32'd1);
        end
        read_status("noblink_status", 1'b1);
`endif

        // Simultaneous read and write to DATA
        do_write(NUMLED_ADDR_DATA, 4'hF, 32'hA5A5_A5A5);
        @(negedge clk);
        io_we = 1'b1; io_re = 1'b1; io_addr = NUMLED_ADDR_DATA;
        io_be = 4'hF; io_wdata = 32'hFFFF_FFFF;
        sb_q.push_back(32'hA5A5_A5A5);
        @(negedge clk);
        io_we = 1'b0; io_re = 1'b0; io_be = 4'd0;
        check("rw_rdata", io_rdata, sb_q.pop_front());
        check("rw_num_out", num_out, 32'hFFFF_FFFF);

        // Writes to STATUS and offset 3 are ignored
        do_write(NUMLED_ADDR_STATUS, 4'hF, 32'h0000_0000);
        do_write(2'd3, 4'hF, 32'h0000_0000);
        check("ro_num_out", num_out, 32'hFFFF_FFFF);
        check("ro_light", {31'd0, light}, 32'd1);
        do_read("ro_ctrl_rd", NUMLED_ADDR_CTRL, 32'h1);
        do_read("off3_rd", 2'd3, 32'd0);

        // Reset mid-operation
        do_read("pre_rst_rd", NUMLED_ADDR_DATA, 32'hFFFF_FFFF);
        reset_and_check("mid_rst");
        do_read("post_rst_ctrl", NUMLED_ADDR_CTRL, 32'h0);
        read_status("post_rst_status", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
